// File: rtl/s1_event_logger_if.sv
// Readout handshake between the S1 event logger and whatever drains its FIFO.
// The logger is the master: it offers head entries, and the reader answers with rd_ready.
interface s1_event_logger_if #(
    parameter int TS_W = 8
);
    logic              rd_valid;
    logic              rd_ready;
    logic [TS_W+1:0]   rd_data;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/s1_event_logger.sv
// Logs S1 detection pulses as {state1, timestamp} entries in a small FIFO drained over valid/ready.
// Also keeps a saturating event count and a sticky drop flag.
module s1_event_logger #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 8,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  y1,
    input  logic [1:0]            state1,
    input  logic                  clr,
    s1_event_logger_if.master     rd,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      evt_count,
    output logic                  overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

    logic [TS_W+1:0] mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     occ;
    logic [TS_W-1:0] ts;
    logic            pop;
    logic            wr_en;
    logic            drop;

    assign full        = (occ == OCC_FULL);
    assign empty       = (occ == '0);
    assign rd.rd_valid = !empty;
    assign rd.rd_data  = empty ? '0 : mem[rd_ptr];

    // A full FIFO still accepts an event when the head leaves at the same edge.
    assign pop   = !empty && rd.rd_ready;
    assign wr_en = y1 && (!full || pop);
    assign drop  = y1 && full && !pop;

    always_ff @(posedge clk) begin
        if (wr_en && !clr) begin
            mem[wr_ptr] <= {state1, ts};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occ       <= '0;
            ts        <= '0;
            evt_count <= '0;
            overflow  <= 1'b0;
        end else if (clr) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occ       <= '0;
            ts        <= '0;
            evt_count <= '0;
            overflow  <= 1'b0;
        end else begin
            ts <= ts + TS_W'(1);
            if (y1 && (evt_count != '1)) begin
                evt_count <= evt_count + CNT_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end
endmodule

// File: tb/tb_s1_event_logger.sv
// Directed bench for s1_event_logger (DEPTH=4, TS_W=8, CNT_W=8) with hand-computed entries.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
module tb_s1_event_logger;
    logic       clk;
    logic       reset;
    logic       y1;
    logic [1:0] state1;
    logic       clr;
    logic       full;
    logic       empty;
    logic [7:0] evt_count;
    logic       overflow;

    int n_compared;
    int n_mismatched;

    s1_event_logger_if #(.TS_W(8)) rd_if ();

    s1_event_logger #(.DEPTH(4), .TS_W(8), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .y1        (y1),
        .state1    (state1),
        .clr       (clr),
        .rd        (rd_if),
        .full      (full),
        .empty     (empty),
        .evt_count (evt_count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // After this, the next rising edge captures timestamp 0.
    task automatic clear_sync();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        y1 = 1'b0;
        state1 = 2'b00;
        clr = 1'b0;
        rd_if.rd_ready = 1'b0;
        #23;
        n_compared++;
        if (empty !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
        n_compared++;
        if (full !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
        n_compared++;
        if (rd_if.rd_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", rd_if.rd_valid); end
        n_compared++;
        if (rd_if.rd_data !== 10'h000) begin n_mismatched++; $display("[TB] FAIL reset_data: got %h expected 000", rd_if.rd_data); end
        n_compared++;
        if (evt_count !== 8'd0) begin n_mismatched++; $display("[TB] FAIL reset_count: got %0d expected 0", evt_count); end
        n_compared++;
        if (overflow !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single_event();
        clear_sync();
        repeat (5) tick();
        y1 = 1'b1;
        state1 = 2'b11;
        tick();
        y1 = 1'b0;
        n_compared++;
        if (rd_if.rd_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_valid: got %b expected 1", rd_if.rd_valid); end
        n_compared++;
        if (rd_if.rd_data !== 10'h305) begin n_mismatched++; $display("[TB] FAIL single_data: got %h expected 305", rd_if.rd_data); end
        n_compared++;
        if (evt_count !== 8'd1) begin n_mismatched++; $display("[TB] FAIL single_count: got %0d expected 1", evt_count); end
        n_compared++;
        if (empty !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_empty: got %b expected 0", empty); end
        tick();
        n_compared++;
        if (rd_if.rd_data !== 10'h305) begin n_mismatched++; $display("[TB] FAIL single_hold: got %h expected 305", rd_if.rd_data); end
        rd_if.rd_ready = 1'b1;
        tick();
        rd_if.rd_ready = 1'b0;
        n_compared++;
        if (empty !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_drain: got %b expected 1", empty); end
    endtask

    task automatic test_fill_drain();
        logic [9:0] exp_q [4];
        logic [1:0] st_q [4];
        exp_q[0] = 10'h102; exp_q[1] = 10'h204; exp_q[2] = 10'h306; exp_q[3] = 10'h108;
        st_q[0] = 2'b01; st_q[1] = 2'b10; st_q[2] = 2'b11; st_q[3] = 2'b01;
        clear_sync();
        for (int t = 0; t < 9; t++) begin
            y1 = (t >= 2) && (t % 2 == 0);
            state1 = (t >= 2) ? st_q[(t - 2) / 2] : 2'b00;
            tick();
            if (t == 6) begin
                n_compared++;
                if (full !== 1'b0) begin n_mismatched++; $display("[TB] FAIL fill_full_early: got %b expected 0", full); end
            end
        end
        y1 = 1'b0;
        n_compared++;
        if (full !== 1'b1) begin n_mismatched++; $display("[TB] FAIL fill_full: got %b expected 1", full); end
        n_compared++;
        if (evt_count !== 8'd4) begin n_mismatched++; $display("[TB] FAIL fill_count: got %0d expected 4", evt_count); end
        rd_if.rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_compared++;
            if (rd_if.rd_data !== exp_q[i]) begin n_mismatched++; $display("[TB] FAIL fill_order%0d: got %h expected %h", i, rd_if.rd_data, exp_q[i]); end
            tick();
        end
        rd_if.rd_ready = 1'b0;
        n_compared++;
        if (empty !== 1'b1) begin n_mismatched++; $display("[TB] FAIL drain_empty: got %b expected 1", empty); end
    endtask

    task automatic test_overflow_drop();
        clear_sync();
        y1 = 1'b1;
        state1 = 2'b10;
        repeat (4) tick();
        n_compared++;
        if (overflow !== 1'b0) begin n_mismatched++; $display("[TB] FAIL drop_pre_overflow: got %b expected 0", overflow); end
        state1 = 2'b01;
        tick();
        y1 = 1'b0;
        n_compared++;
        if (overflow !== 1'b1) begin n_mismatched++; $display("[TB] FAIL drop_overflow: got %b expected 1", overflow); end
        n_compared++;
        if (evt_count !== 8'd5) begin n_mismatched++; $display("[TB] FAIL drop_count: got %0d expected 5", evt_count); end
        n_compared++;
        if (rd_if.rd_data !== 10'h200) begin n_mismatched++; $display("[TB] FAIL drop_head: got %h expected 200", rd_if.rd_data); end
        n_compared++;
        if (full !== 1'b1) begin n_mismatched++; $display("[TB] FAIL drop_full: got %b expected 1", full); end
        tick();
        n_compared++;
        if (overflow !== 1'b1) begin n_mismatched++; $display("[TB] FAIL drop_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_q [4];
        exp_q[0] = 10'h101; exp_q[1] = 10'h102; exp_q[2] = 10'h103; exp_q[3] = 10'h304;
        clear_sync();
        y1 = 1'b1;
        state1 = 2'b01;
        repeat (4) tick();
        state1 = 2'b11;
        rd_if.rd_ready = 1'b1;
        tick();
        y1 = 1'b0;
        rd_if.rd_ready = 1'b0;
        n_compared++;
        if (full !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_full: got %b expected 1", full); end
        n_compared++;
        if (overflow !== 1'b0) begin n_mismatched++; $display("[TB] FAIL b2b_overflow: got %b expected 0", overflow); end
        n_compared++;
        if (evt_count !== 8'd5) begin n_mismatched++; $display("[TB] FAIL b2b_count: got %0d expected 5", evt_count); end
        rd_if.rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_compared++;
            if (rd_if.rd_data !== exp_q[i]) begin n_mismatched++; $display("[TB] FAIL b2b_order%0d: got %h expected %h", i, rd_if.rd_data, exp_q[i]); end
            tick();
        end
        rd_if.rd_ready = 1'b0;
        n_compared++;
        if (empty !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_empty: got %b expected 1", empty); end
    endtask

    // One entry streams through per cycle, so the head always carries this edge's timestamp.
    task automatic test_saturate_wrap();
        logic [7:0] exp_cnt;
        clear_sync();
        y1 = 1'b1;
        state1 = 2'b10;
        rd_if.rd_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            tick();
            exp_cnt = (k >= 254) ? 8'd255 : 8'(k + 1);
            n_compared++;
            if (rd_if.rd_data !== {2'b10, k[7:0]}) begin n_mismatched++; $display("[TB] FAIL wrap_ts%0d: got %h expected %h", k, rd_if.rd_data, {2'b10, k[7:0]}); end
            n_compared++;
            if (evt_count !== exp_cnt) begin n_mismatched++; $display("[TB] FAIL sat_count%0d: got %0d expected %0d", k, evt_count, exp_cnt); end
        end
        y1 = 1'b0;
        tick();
        rd_if.rd_ready = 1'b0;
        n_compared++;
        if (empty !== 1'b1) begin n_mismatched++; $display("[TB] FAIL sat_empty: got %b expected 1", empty); end
    endtask

    task automatic setup_midstream();
        clear_sync();
        y1 = 1'b1;
        state1 = 2'b11;
        repeat (5) tick();
        y1 = 1'b0;
        rd_if.rd_ready = 1'b1;
        repeat (2) tick();
        rd_if.rd_ready = 1'b0;
        n_compared++;
        if ({empty, full, overflow} !== 3'b001) begin n_mismatched++; $display("[TB] FAIL mid_setup: got %b expected 001", {empty, full, overflow}); end
    endtask

    task automatic test_clear_midstream();
        setup_midstream();
        clr = 1'b1;
        y1 = 1'b1;
        tick();
        clr = 1'b0;
        y1 = 1'b0;
        n_compared++;
        if (empty !== 1'b1) begin n_mismatched++; $display("[TB] FAIL clr_empty: got %b expected 1", empty); end
        n_compared++;
        if (evt_count !== 8'd0) begin n_mismatched++; $display("[TB] FAIL clr_count: got %0d expected 0", evt_count); end
        n_compared++;
        if (overflow !== 1'b0) begin n_mismatched++; $display("[TB] FAIL clr_overflow: got %b expected 0", overflow); end
        n_compared++;
        if (rd_if.rd_data !== 10'h000) begin n_mismatched++; $display("[TB] FAIL clr_data: got %h expected 000", rd_if.rd_data); end
        y1 = 1'b1;
        state1 = 2'b10;
        tick();
        y1 = 1'b0;
        n_compared++;
        if (rd_if.rd_data !== 10'h200) begin n_mismatched++; $display("[TB] FAIL clr_ts: got %h expected 200", rd_if.rd_data); end
    endtask

    task automatic test_async_reset();
        setup_midstream();
        #2;
        reset = 1'b0;
        #1;
        n_compared++;
        if (empty !== 1'b1) begin n_mismatched++; $display("[TB] FAIL arst_empty: got %b expected 1", empty); end
        n_compared++;
        if (evt_count !== 8'd0) begin n_mismatched++; $display("[TB] FAIL arst_count: got %0d expected 0", evt_count); end
        n_compared++;
        if (overflow !== 1'b0) begin n_mismatched++; $display("[TB] FAIL arst_overflow: got %b expected 0", overflow); end
        #2;
        reset = 1'b1;
        y1 = 1'b1;
        state1 = 2'b01;
        tick();
        y1 = 1'b0;
        n_compared++;
        if (rd_if.rd_data !== 10'h100) begin n_mismatched++; $display("[TB] FAIL arst_ts: got %h expected 100", rd_if.rd_data); end
        n_compared++;
        if (evt_count !== 8'd1) begin n_mismatched++; $display("[TB] FAIL arst_post_count: got %0d expected 1", evt_count); end
    endtask

    initial begin
        n_compared = 0;
        n_mismatched = 0;
        test_reset();
        test_single_event();
        test_fill_drain();
        test_overflow_drop();
        test_back_to_back();
        test_saturate_wrap();
        test_clear_midstream();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/s1_event_logger.md
Name: s1_event_logger

Overview:
- Downstream consumer of the S1 sequence-detector outputs (Y1, state1).
- Samples Y1 every clock. Each high sample is a detection event, tagged with the concurrent state1 value and a free-running cycle timestamp, and pushed into a small FIFO.
- A readout agent drains the FIFO over a valid/ready handshake.
- Also keeps a saturating total-event count and a sticky overflow flag for drops.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
TS_W, 8, timestamp counter width in bits
CNT_W, 8, event counter width in bits

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
y1  input  1  detection pulse from S1 (Mealy, combinational; sampled only at clk rise)
state1  input  2  S1 current state, sampled with y1
clr  input  1  synchronous clear of FIFO, counters, overflow
rd_ready  input  1  reader accepts head entry this cycle
rd_valid  output  1  FIFO non-empty, rd_data meaningful
rd_data  output  TS_W+2  {state1_at_event[1:0], timestamp[TS_W-1:0]} of head entry
full  output  1  FIFO holds DEPTH entries
empty  output  1  FIFO holds 0 entries
evt_count  output  CNT_W  total events seen, saturating
overflow  output  1  sticky; at least one event dropped

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO pointers and occupancy reset to 0, so empty=1, full=0, rd_valid=0.
  - rd_data=0, timestamp counter=0, evt_count=0, overflow=0.
  - Storage contents need not be cleared, but rd_data must read 0 while empty.
- Timestamp: TS_W-bit counter, +1 every clock, wraps from all-ones to 0. It is not stalled by FIFO state.
- Event definition and write:
  - Event = y1==1 at a rising edge. Consecutive high cycles are separate events.
  - The captured entry is {state1, ts}, where ts is the counter value before that edge's increment.
- Write/read ordering: pop = rd_valid && rd_ready. Write succeeds if !full, or if full && pop at the same edge.
- Occupancy at one edge:
  - write only: occupancy +1
  - pop only: occupancy −1
  - write and pop together: occupancy unchanged, head advances, tail advances
- Drop: event && full && !pop.
  - Entry is discarded and overflow<=1, which stays set until reset or clr.
  - FIFO contents are unchanged.
- evt_count:
  - +1 on every event, including dropped ones.
  - Holds at 2^CNT_W−1 with no wrap.
- Latency: an event captured at edge N into an empty FIFO gives rd_valid=1 and rd_data valid in the cycle after edge N, i.e. 1 cycle.
- Read side:
  - rd_data is driven from the registered head entry and is stable while rd_valid && !rd_ready.
  - rd_ready while empty has no effect.
- Pointers: log2(DEPTH)-bit indices, wrap modulo DEPTH. full/empty are derived from an occupancy counter of width log2(DEPTH)+1.
- clr=1 at an edge:
  - Occupancy, pointers, timestamp, evt_count and overflow go to 0.
  - An event or pop at the same edge is ignored.
  - clr has priority over all other synchronous activity.
- Reset mid-operation: asserting reset immediately forces all reset values regardless of clk. Deassertion is synchronous-safe; the first active edge after release behaves as post-reset.
- Outputs full, empty, rd_valid, overflow and evt_count are registered-state derived, with no combinational path from y1.

Test Plan:
- Reset, then y1=1, state1=2'b11 for one cycle at ts=5, rd_ready=0:
  - next cycle rd_valid=1, rd_data={2'b11,8'd5}
  - evt_count=1, empty=0
- Four single-cycle events at ts=2,4,6,8 (state1=01,10,11,01), then rd_ready=1 for 4 cycles:
  - entries read in order
  - full=1 after 4th write, empty=1 after 4th pop
- FIFO full, one more event with rd_ready=0:
  - entry dropped, overflow=1, evt_count increments
  - rd_data still the oldest entry
- FIFO full, event with rd_ready=1 at the same edge:
  - head popped and new entry written, full stays 1, overflow stays 0
- y1 held high 300 cycles with rd_ready=1, CNT_W=8:
  - evt_count saturates at 255
  - timestamps on rd_data wrap 255→0 with no gap
- Mid-stream (2 entries queued, overflow=1):
  - clr=1 with y1=1 gives empty=1, evt_count=0, overflow=0 next cycle
  - repeating the setup and dropping reset to 0 between edges gives the same values asynchronously
